lif_update_ctrl: RTL



---
 rtl/snn_pkg.sv | 56 +++++
 rtl/lif_neuron_alu.sv | 40 ++++
 rtl/lif_update_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and arithmetic helpers for the LIF update datapath.
// Potentials and currents are two's complement, POT_WIDTH bits wide.
package snn_pkg;

    localparam int POT_WIDTH = 32;

    typedef logic signed [POT_WIDTH-1:0] potential_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        FLUSH = 2'd2
    } lif_state_t;

    localparam potential_t POT_MAX = {1'b0, {(POT_WIDTH-1){1'b1}}};
    localparam potential_t POT_MIN = {1'b1, {(POT_WIDTH-1){1'b0}}};

    // a + b, clamped to the signed range instead of wrapping
    function automatic potential_t sat_add(input potential_t a, input potential_t b);
        logic [POT_WIDTH:0] sum;
        potential_t         res;
        sum = {a[POT_WIDTH-1], a} + {b[POT_WIDTH-1], b};
        if (sum[POT_WIDTH] != sum[POT_WIDTH-1]) begin
            res = sum[POT_WIDTH] ? POT_MIN : POT_MAX;
        end else begin
            res = sum[POT_WIDTH-1:0];
        end
        return res;
    endfunction

    // a - b, clamped to the signed range instead of wrapping
    function automatic potential_t sat_sub(input potential_t a, input potential_t b);
        logic [POT_WIDTH:0] diff;
        potential_t         res;
        diff = {a[POT_WIDTH-1], a} - {b[POT_WIDTH-1], b};
        if (diff[POT_WIDTH] != diff[POT_WIDTH-1]) begin
            res = diff[POT_WIDTH] ? POT_MIN : POT_MAX;
        end else begin
            res = diff[POT_WIDTH-1:0];
        end
        return res;
    endfunction

    // One time step of decay: v - (v >>> shift). A shift of 0 means no leak.
    // For shift >= 1 the result always stays in range, so no clamp is needed.
    function automatic potential_t leak(input potential_t v, input int unsigned shift);
        potential_t res;
        if (shift == 0) begin
            res = v;
        end else begin
            res = v - (v >>> shift);
        end
        return res;
    endfunction

endpackage

// File: rtl/lif_neuron_alu.sv
// Combinational integrate-and-fire step for one neuron:
//   s = sat_add(v, current); fire = (s >= threshold)
//   next_v = s when not firing, otherwise the post-fire reset value.
// Build option SOFT_RESET_EN: post-fire value is sat(s - threshold)
// instead of 0. Spike signalling is the same either way.
module lif_neuron_alu
    import snn_pkg::*;
#(
    parameter int WIDTH = POT_WIDTH
) (
    input  logic [WIDTH-1:0] v,
    input  logic [WIDTH-1:0] current,
    input  logic [WIDTH-1:0] threshold,
    output logic [WIDTH-1:0] next_v,
    output logic             fire
);

    potential_t v_s;
    potential_t cur_s;
    potential_t thr_s;
    potential_t sum_s;

    // Integrate, compare against threshold, choose the written-back value
    always_comb begin
        v_s    = v;
        cur_s  = current;
        thr_s  = threshold;
        sum_s  = sat_add(v_s, cur_s);
        fire   = (sum_s >= thr_s);
        next_v = sum_s;
        if (fire) begin
`ifdef SOFT_RESET_EN
            next_v = sat_sub(sum_s, thr_s);
`else
            next_v = '0;
`endif
        end
    end

endmodule

// File: rtl/lif_update_ctrl.sv
// Leaky-integrate-and-fire update controller for one layer's potential RAM
// (1-cycle registered read, synchronous write).
//
// Event path: accepted at T -> read issued at T, ALU + writeback at T+1,
// registered spike at T+2. Back-to-back events to the same neuron take the
// previous writeback value from a forwarding register, because the RAM read
// issued at T+1 sees the old contents while the T+1 write is still pending.
//
// Leak sweep: step_start in IDLE starts a read of every neuron in order
// (SWEEP), each read is written back leaked one cycle later, and the final
// writeback happens in FLUSH where step_done pulses.
//
// Build option SOFT_RESET_EN (in lif_neuron_alu): subtractive reset on fire.
module lif_update_ctrl
    import snn_pkg::*;
#(
    parameter int WIDTH      = POT_WIDTH,
    parameter int DEPTH      = 16,
    parameter int LEAK_SHIFT = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    in_addr,
    input  logic [WIDTH-1:0] in_current,
    input  logic [WIDTH-1:0] threshold,
    input  logic             step_start,
    output logic             step_done,
    output logic             busy,
    output logic             spike_valid,
    output logic [AW-1:0]    spike_addr,
    output logic             mem_read_en,
    output logic [AW-1:0]    mem_read_addr,
    input  logic [WIDTH-1:0] mem_read_data,
    output logic             mem_write_en,
    output logic [AW-1:0]    mem_write_addr,
    output logic [WIDTH-1:0] mem_write_data,
    output logic [1:0]       dbg_state
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    // Handshake: an event transfers on any rising clk edge where
    // in_valid && in_ready; in_addr/in_current must be stable while in_valid
    // is high; in_ready may drop without in_valid being withdrawn, and the
    // source keeps presenting the event until it transfers.

    lif_state_t       state;
    lif_state_t       state_nxt;
    logic [AW-1:0]    sweep_cnt;
    logic             accept;

    logic             s1_valid;
    logic [AW-1:0]    s1_addr;
    logic [WIDTH-1:0] s1_cur;

    logic             fwd_valid;
    logic [AW-1:0]    fwd_addr;
    logic [WIDTH-1:0] fwd_data;

    logic             lk_valid;
    logic [AW-1:0]    lk_addr;

    logic [WIDTH-1:0] v_sel;
    logic [WIDTH-1:0] alu_next;
    logic             alu_fire;
    potential_t       leak_in;
    potential_t       leak_out;

    // Ready only in IDLE and never in the cycle a sweep is requested
    always_comb begin
        in_ready  = rst && (state == IDLE) && !step_start;
        accept    = in_valid && in_ready;
        busy      = s1_valid || (state != IDLE);
        dbg_state = state;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and sweep-completion pulse
    always_comb begin
        state_nxt = state;
        step_done = 1'b0;
        case (state)
            IDLE: begin
                if (step_start) begin
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                if (sweep_cnt == LAST_ADDR) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                step_done = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sweep address counter: holds at the last neuron, never wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sweep_cnt <= '0;
        end else if (state != SWEEP) begin
            sweep_cnt <= '0;
        end else if (sweep_cnt != LAST_ADDR) begin
            sweep_cnt <= sweep_cnt + AW'(1);
        end
    end

    // Sweep writeback tag: the address read in the previous SWEEP cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lk_valid <= 1'b0;
            lk_addr  <= '0;
        end else begin
            lk_valid <= (state == SWEEP);
            lk_addr  <= sweep_cnt;
        end
    end

    // Event stage 1: remembers the accepted event while its read returns
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_cur   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_addr <= in_addr;
                s1_cur  <= in_current;
            end
        end
    end

    // Forwarding register: last event writeback, valid for one cycle only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
        end else begin
            fwd_valid <= s1_valid;
            if (s1_valid) begin
                fwd_addr <= s1_addr;
                fwd_data <= alu_next;
            end
        end
    end

    // Operand select: forwarded value beats the stale RAM read
    always_comb begin
        v_sel = mem_read_data;
        if (fwd_valid && (fwd_addr == s1_addr)) begin
            v_sel = fwd_data;
        end
    end

    lif_neuron_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .v         (v_sel),
        .current   (s1_cur),
        .threshold (threshold),
        .next_v    (alu_next),
        .fire      (alu_fire)
    );

    // Registered spike output, one cycle after the writeback
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spike_valid <= 1'b0;
            spike_addr  <= '0;
        end else begin
            spike_valid <= s1_valid && alu_fire;
            if (s1_valid && alu_fire) begin
                spike_addr <= s1_addr;
            end
        end
    end

    // Memory read port: event reads in IDLE, sweep reads in SWEEP
    always_comb begin
        mem_read_en   = 1'b0;
        mem_read_addr = '0;
        if (accept) begin
            mem_read_en   = 1'b1;
            mem_read_addr = in_addr;
        end else if (state == SWEEP) begin
            mem_read_en   = 1'b1;
            mem_read_addr = sweep_cnt;
        end
    end

    // Memory write port: event and sweep writebacks never coincide, since
    // events are only accepted in IDLE and sweep writebacks start one cycle
    // after the first SWEEP read
    always_comb begin
        leak_in        = mem_read_data;
        leak_out       = leak(leak_in, LEAK_SHIFT);
        mem_write_en   = 1'b0;
        mem_write_addr = '0;
        mem_write_data = '0;
        if (s1_valid) begin
            mem_write_en   = 1'b1;
            mem_write_addr = s1_addr;
            mem_write_data = alu_next;
        end else if (lk_valid) begin
            mem_write_en   = 1'b1;
            mem_write_addr = lk_addr;
            mem_write_data = leak_out;
        end
    end

endmodule
